// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM arbiter: FSM state encoding, grant owner codes
// and default bus widths.
package ram_arb_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ISSUE   = 2'd1;
  localparam state_t ST_CAPTURE = 2'd2;

  typedef logic [1:0] owner_t;
  localparam owner_t OWN_NONE  = 2'd0;
  localparam owner_t OWN_FLASH = 2'd1;
  localparam owner_t OWN_CPU   = 2'd2;
  localparam owner_t OWN_DIAG  = 2'd3;

  // Ack vector layout used throughout: bit 0 flash, bit 1 cpu, bit 2 diag.
  function automatic logic [2:0] owner_onehot(input owner_t own);
    case (own)
      OWN_FLASH: return 3'b001;
      OWN_CPU:   return 3'b010;
      OWN_DIAG:  return 3'b100;
      default:   return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ram_arb_if.sv
// Requester-side handshake of the RAM arbiter: level req held until a one-cycle ack,
// with read data held from that ack until the next one.
interface ram_req_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ram_arb_pick.sv
// Combinational fixed-priority picker (cpu > flash > diag) applying boot/halt
// eligibility and masking the requester whose ack is high this cycle.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic       boot_done,
  input  logic       halt,
  input  logic       flash_req,
  input  logic       cpu_req,
  input  logic       diag_req,
  input  logic [2:0] ack_mask,
  output logic       cpu_elig,
  output owner_t     grant
);

  logic flash_elig;
  logic diag_elig;

  assign flash_elig = !boot_done;
  assign cpu_elig   = boot_done && !halt;
  assign diag_elig  = boot_done;

  always_comb begin
    // NOTE: default first so every path assigns grant and no latch is inferred.
    grant = OWN_NONE;
    if (cpu_req && cpu_elig && !ack_mask[1])
      grant = OWN_CPU;
    else if (flash_req && flash_elig && !ack_mask[0])
      grant = OWN_FLASH;
    else if (diag_req && diag_elig && !ack_mask[2])
      grant = OWN_DIAG;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Sequences every access to the single-port sram64k among flash loader, CPU and
// diagnostics (IDLE -> ISSUE -> CAPTURE), and flags CPU requests that wait too long.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_done,
  input  logic              halt,
  ram_req_if.slave          flash,
  ram_req_if.slave          cpu,
  ram_req_if.slave          diag,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_datain,
  output logic              ram_cs,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dataout,
  output owner_t            owner,
  output logic              cpu_overrun
);

  // Wide enough to count one past CPU_MAX_WAIT, never narrower than 3 bits.
  localparam int WAIT_W = ($clog2(CPU_MAX_WAIT + 2) > 3) ? $clog2(CPU_MAX_WAIT + 2) : 3;

  state_t            state;
  owner_t            grant;
  logic              cpu_elig;
  logic [2:0]        ack_q;
  logic              op_we;
  logic [DATA_W-1:0] flash_rdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] diag_rdata_q;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [WAIT_W-1:0] cpu_wait;
  logic [WAIT_W-1:0] cpu_wait_next;
  logic              cpu_served;

  ram_arb_pick u_pick (
    .boot_done (boot_done),
    .halt      (halt),
    .flash_req (flash.req),
    .cpu_req   (cpu.req),
    .diag_req  (diag.req),
    .ack_mask  (ack_q),
    .cpu_elig  (cpu_elig),
    .grant     (grant)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    case (grant)
      OWN_FLASH: begin
        sel_we    = flash.we;
        sel_addr  = flash.addr;
        sel_wdata = flash.wdata;
      end
      OWN_CPU: begin
        sel_we    = cpu.we;
        sel_addr  = cpu.addr;
        sel_wdata = cpu.wdata;
      end
      OWN_DIAG: begin
        sel_we    = diag.we;
        sel_addr  = diag.addr;
        sel_wdata = diag.wdata;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      ram_address <= '0;
      ram_datain  <= '0;
      ram_cs      <= 1'b0;
      ram_we      <= 1'b0;
      op_we       <= 1'b0;
      owner       <= OWN_NONE;
      ack_q       <= '0;
    end else begin
      ack_q <= '0;
      case (state)
        ST_IDLE: begin
          if (grant != OWN_NONE) begin
            state       <= ST_ISSUE;
            owner       <= grant;
            ram_address <= sel_addr;
            ram_datain  <= sel_wdata;
            ram_we      <= sel_we;
            op_we       <= sel_we;
            ram_cs      <= 1'b1;
          end else begin
            ram_cs <= 1'b0;
            ram_we <= 1'b0;
          end
        end
        ST_ISSUE: begin
          state  <= ST_CAPTURE;
          ram_cs <= 1'b0;
          ram_we <= 1'b0;
        end
        ST_CAPTURE: begin
          state <= ST_IDLE;
          ack_q <= owner_onehot(owner);
        end
        default: begin
          state  <= ST_IDLE;
          ram_cs <= 1'b0;
          ram_we <= 1'b0;
        end
      endcase
    end
  end

  // The RAM output register holds this access's read data during CAPTURE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flash_rdata_q <= '0;
      cpu_rdata_q   <= '0;
      diag_rdata_q  <= '0;
    end else if (state == ST_CAPTURE && !op_we) begin
      case (owner)
        OWN_FLASH: flash_rdata_q <= ram_dataout;
        OWN_CPU:   cpu_rdata_q   <= ram_dataout;
        OWN_DIAG:  diag_rdata_q  <= ram_dataout;
        default: ;
      endcase
    end
  end

  assign flash.ack   = ack_q[0];
  assign cpu.ack     = ack_q[1];
  assign diag.ack    = ack_q[2];
  assign flash.rdata = flash_rdata_q;
  assign cpu.rdata   = cpu_rdata_q;
  assign diag.rdata  = diag_rdata_q;

  // A CPU access that is being granted, in flight or acked is not waiting.
  assign cpu_served = ack_q[1]
                   || (state == ST_IDLE && grant == OWN_CPU)
                   || (state != ST_IDLE && owner == OWN_CPU);

  always_comb begin
    cpu_wait_next = '0;
    if (cpu.req && cpu_elig && !cpu_served)
      cpu_wait_next = (&cpu_wait) ? cpu_wait : cpu_wait + WAIT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_wait    <= '0;
      cpu_overrun <= 1'b0;
    end else begin
      cpu_wait <= cpu_wait_next;
      if (cpu_wait_next > WAIT_W'(CPU_MAX_WAIT))
        cpu_overrun <= 1'b1;
    end
  end

endmodule
